// File: rtl/key_matrix_scan_pkg.sv
// Shared key-matrix dimensions, types and the one-hot active-low row decode
// used by both the key scanner and the LED matrix driver.
package key_matrix_scan_pkg;

   localparam int unsigned KEY_ROWS  = 4;
   localparam int unsigned KEY_COLS  = 4;
   localparam int unsigned KEY_NUM   = KEY_ROWS * KEY_COLS;
   localparam int unsigned ROW_IDX_W = $clog2(KEY_ROWS);
   localparam int unsigned KEY_IDX_W = $clog2(KEY_NUM);

   typedef logic [ROW_IDX_W-1:0] row_idx_t;
   typedef logic [KEY_IDX_W-1:0] key_idx_t;
   typedef logic [KEY_ROWS-1:0]  row_drv_t;
   typedef logic [KEY_COLS-1:0]  col_t;
   typedef logic [KEY_NUM-1:0]   key_map_t;

   // Exactly one row driven low; all others released high.
   function automatic row_drv_t row_decode_n(input row_idx_t idx);
      row_drv_t drv;
      drv      = '1;
      drv[idx] = 1'b0;
      return drv;
   endfunction

   function automatic row_idx_t row_next(input row_idx_t idx);
      return idx + row_idx_t'(1);
   endfunction

endpackage

// File: rtl/key_matrix_scan_pri_enc16.sv
// Combinational lowest-set-bit encoder over a 16-bit key map.
module pri_enc16
   import key_matrix_scan_pkg::*;
(
   input  logic [KEY_NUM-1:0]   vec_i,
   output logic [KEY_IDX_W-1:0] idx_o,
   output logic                 nz_o
);

   // Scan from the top down so the lowest set bit is written last and wins.
   always_comb begin
      idx_o = '0;
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
         if (vec_i[KEY_IDX_W'(KEY_NUM - 1 - i)]) begin
            idx_o = KEY_IDX_W'(KEY_NUM - 1 - i);
         end
      end
   end

   assign nz_o = |vec_i;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: row strobe, column synchroniser,
// whole-frame debounce and single press-event reporting.
module key_matrix_scan
   import key_matrix_scan_pkg::*;
#(
   parameter int unsigned DWELL    = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic                 clk1K,
   input  logic                 rst,
   input  logic [KEY_COLS-1:0]  colI,
   output logic [KEY_ROWS-1:0]  rowO,
   output logic [KEY_NUM-1:0]   keys,
   output logic [KEY_IDX_W-1:0] keyCode,
   output logic                 keyValid,
   output logic                 keyDown
);

   localparam int unsigned DW_W = $clog2(DWELL);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
   localparam logic [3:0]      DB_MAX  = 4'(DEBOUNCE);

   col_t                 col_s1_q, col_s2_q;
   row_idx_t             row_idx_q, row_idx_d;
   logic [DW_W-1:0]      dwell_q, dwell_d;
   row_drv_t             row_o_q, row_o_d;
   key_map_t             raw_q, raw_d;
   key_map_t             prev_q, prev_d;
   logic [3:0]           stable_q, stable_d;
   key_map_t             keys_q, keys_d;
   key_idx_t             code_q, code_d;
   logic                 valid_q, valid_d;
   logic                 down_q, down_d;

   logic                 row_end;
   logic                 frame_end;
   key_map_t             frame_w;
   key_map_t             new_press;
   key_idx_t             press_idx;
   logic                 press_nz;

   assign row_end   = (dwell_q == DW_LAST);
   assign frame_end = row_end && (row_idx_q == ROW_IDX_W'(KEY_ROWS - 1));

   // Raw map with the current row's columns merged in; on the last row this is the finished frame.
   always_comb begin
      frame_w = raw_q;
      for (int unsigned c = 0; c < KEY_COLS; c++) begin
         frame_w[{row_idx_q, ROW_IDX_W'(c)}] = ~col_s2_q[ROW_IDX_W'(c)];
      end
   end

   assign new_press = frame_w & ~keys_q;

   pri_enc16 u_pri_enc16 (
      .vec_i (new_press),
      .idx_o (press_idx),
      .nz_o  (press_nz)
   );

   always_comb begin
      row_idx_d = row_idx_q;
      dwell_d   = dwell_q + 1'b1;
      row_o_d   = row_o_q;
      raw_d     = raw_q;
      prev_d    = prev_q;
      stable_d  = stable_q;
      keys_d    = keys_q;
      code_d    = code_q;
      valid_d   = 1'b0;

      if (row_end) begin
         dwell_d   = '0;
         row_idx_d = row_next(row_idx_q);
         row_o_d   = row_decode_n(row_idx_d);
         raw_d     = frame_w;
      end

      if (frame_end) begin
         prev_d = frame_w;
         if (frame_w == prev_q) begin
            stable_d = (stable_q == DB_MAX) ? stable_q : stable_q + 4'd1;
         end else begin
            stable_d = 4'd1;
         end
         // Only newly pressed keys raise an event; releases update the map silently.
         if ((stable_d == DB_MAX) && (frame_w != keys_q)) begin
            keys_d = frame_w;
            if (press_nz) begin
               code_d  = press_idx;
               valid_d = 1'b1;
            end
         end
      end

      down_d = |keys_d;
   end

   always_ff @(posedge clk1K or posedge rst) begin
      if (rst) begin
         col_s1_q  <= '1;
         col_s2_q  <= '1;
         row_idx_q <= '0;
         dwell_q   <= '0;
         row_o_q   <= row_decode_n('0);
         raw_q     <= '0;
         prev_q    <= '0;
         stable_q  <= '0;
         keys_q    <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         down_q    <= 1'b0;
      end else begin
         col_s1_q  <= colI;
         col_s2_q  <= col_s1_q;
         row_idx_q <= row_idx_d;
         dwell_q   <= dwell_d;
         row_o_q   <= row_o_d;
         raw_q     <= raw_d;
         prev_q    <= prev_d;
         stable_q  <= stable_d;
         keys_q    <= keys_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         down_q    <= down_d;
      end
   end

   assign rowO     = row_o_q;
   assign keys     = keys_q;
   assign keyCode  = code_q;
   assign keyValid = valid_q;
   assign keyDown  = down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench: frame-level reference model of a pressed-key matrix,
// table-driven press sequences, bounce / mid-scan reset corners and random holds.
module tb_key_matrix_scan;

   localparam int DWELL    = 4;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 4 * DWELL;

   logic        clk1K = 1'b0;
   logic        rst   = 1'b1;
   logic [3:0]  colI;
   logic [3:0]  rowO;
   logic [15:0] keys;
   logic [3:0]  keyCode;
   logic        keyValid;
   logic        keyDown;

   logic [15:0] pressed = '0;

   always #5 clk1K = ~clk1K;

   // Physical matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      colI = '1;
      for (int r = 0; r < 4; r++) begin
         if (!rowO[r]) colI = colI & ~pressed[r*4 +: 4];
      end
   end

   key_matrix_scan #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
      .clk1K    (clk1K),
      .rst      (rst),
      .colI     (colI),
      .rowO     (rowO),
      .keys     (keys),
      .keyCode  (keyCode),
      .keyValid (keyValid),
      .keyDown  (keyDown)
   );

   // Reference model state: edge count since reset, pressed history, per-row samples, frame history.
   int          n;
   logic [15:0] p1, p2;
   logic [3:0]  mrow [4];
   logic [15:0] hist [$];
   logic [15:0] m_keys;
   logic [3:0]  m_code;
   logic        m_kv;

   int errors = 0;
   int checks = 0;
   int kv_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0;
      p1 = '0;
      p2 = '0;
      for (int r = 0; r < 4; r++) mrow[r] = '0;
      hist.delete();
      m_keys = '0;
      m_code = '0;
      m_kv   = 1'b0;
   endtask

   task automatic model_step(input logic [15:0] pre);
      logic [15:0] f, np;
      int          r;
      bit          ok;
      n++;
      m_kv = 1'b0;
      if (n % DWELL == 0) begin
         r = (n / DWELL - 1) % 4;
         mrow[r] = p2[r*4 +: 4];
         if (r == 3) begin
            f = {mrow[3], mrow[2], mrow[1], mrow[0]};
            hist.push_back(f);
            if (hist.size() > DEBOUNCE) void'(hist.pop_front());
            ok = (hist.size() == DEBOUNCE);
            foreach (hist[i]) if (hist[i] != f) ok = 0;
            if (ok && f != m_keys) begin
               np = f & ~m_keys;
               if (np != 0) begin
                  m_kv = 1'b1;
                  for (int i = 15; i >= 0; i--) if (np[i]) m_code = 4'(i);
               end
               m_keys = f;
            end
         end
      end
      p2 = p1;
      p1 = pre;
   endtask

   task automatic tick();
      logic [15:0] pre;
      logic [3:0]  er;
      pre = pressed;
      @(posedge clk1K);
      if (rst) model_reset();
      else     model_step(pre);
      @(negedge clk1K);
      if (keyValid) kv_cnt++;
      er = ~(4'b0001 << ((n / DWELL) % 4));
      chk("rowO", rowO, er);
      chk("keys", keys, m_keys);
      chk("keyValid", keyValid, m_kv);
      chk("keyCode", keyCode, m_code);
      chk("keyDown", keyDown, m_keys != 0);
   endtask

   typedef struct {
      logic [15:0] pat;
      int          hold;
      logic [15:0] exp_keys;
      int          exp_pulses;
      logic [3:0]  exp_code;
   } vec_t;

   vec_t       vt [7];
   logic [3:0] seq_tab [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      rst = 1'b1;
      pressed = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_rowO", rowO, 4'b1110);
      chk("rst_keys", keys, 16'h0000);
      chk("rst_keyValid", keyValid, 1'b0);
      rst = 1'b0;

      // Row strobe sequence
      seq_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("scan_seq", rowO, seq_tab[(i / DWELL) % 4]);
      end

      // Table-driven press/release sequences
      vt[0] = '{pat:16'h0200, hold:80,   exp_keys:16'h0200, exp_pulses:1, exp_code:4'd9};
      vt[1] = '{pat:16'h0000, hold:80,   exp_keys:16'h0000, exp_pulses:0, exp_code:4'd9};
      vt[2] = '{pat:16'h1008, hold:80,   exp_keys:16'h1008, exp_pulses:1, exp_code:4'd3};
      vt[3] = '{pat:16'h1009, hold:80,   exp_keys:16'h1009, exp_pulses:1, exp_code:4'd0};
      vt[4] = '{pat:16'h0001, hold:80,   exp_keys:16'h0001, exp_pulses:0, exp_code:4'd0};
      vt[5] = '{pat:16'h8000, hold:1000, exp_keys:16'h8000, exp_pulses:1, exp_code:4'd15};
      vt[6] = '{pat:16'h0000, hold:80,   exp_keys:16'h0000, exp_pulses:0, exp_code:4'd15};
      for (int i = 0; i < 7; i++) begin
         pressed = vt[i].pat;
         kv_cnt  = 0;
         repeat (vt[i].hold) tick();
         chk("vec_keys", keys, vt[i].exp_keys);
         chk("vec_pulses", kv_cnt, vt[i].exp_pulses);
         chk("vec_code", keyCode, vt[i].exp_code);
         chk("vec_keyDown", keyDown, vt[i].exp_keys != 0);
      end

      // Bounce on key 5: phase chosen so no three consecutive frames see it pressed
      for (int g = 0; g < 40 && (n % FRAME) != 14; g++) tick();
      kv_cnt = 0;
      for (int o = 0; o < 200; o++) begin
         pressed = ((o / 10) % 2 == 0) ? 16'h0020 : 16'h0000;
         tick();
      end
      chk("bounce_no_event", kv_cnt, 0);
      chk("bounce_keys", keys, 16'h0000);
      pressed = 16'h0020;
      kv_cnt  = 0;
      repeat (100) tick();
      chk("bounce_hold_pulses", kv_cnt, 1);
      chk("bounce_hold_code", keyCode, 4'd5);
      chk("bounce_hold_keys", keys, 16'h0020);
      pressed = '0;
      repeat (80) tick();

      // Mid-scan reset with key 7 held
      pressed = 16'h0080;
      repeat (80) tick();
      chk("mid_pre_keys", keys, 16'h0080);
      for (int g = 0; g < 32; g++) begin
         if (rowO == 4'b1011) break;
         tick();
      end
      chk("mid_rst_row", rowO, 4'b1011);
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_rowO", rowO, 4'b1110);
      chk("mid_rst_keys", keys, 16'h0000);
      chk("mid_rst_keyValid", keyValid, 1'b0);
      chk("mid_rst_keyCode", keyCode, 4'd0);
      chk("mid_rst_keyDown", keyDown, 1'b0);
      repeat (2) tick();
      rst    = 1'b0;
      kv_cnt = 0;
      repeat (40) tick();
      chk("mid_rst_debounce_wait", keys, 16'h0000);
      repeat (40) tick();
      chk("mid_rst_keys_again", keys, 16'h0080);
      chk("mid_rst_pulses", kv_cnt, 1);
      chk("mid_rst_code", keyCode, 4'd7);

      // Randomized sparse key patterns against the model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0)
            pressed = 16'($urandom & $urandom & $urandom);
         repeat ($urandom_range(5, 90)) tick();
      end
      pressed = '0;
      repeat (80) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
Scans a 4x4 active-low key matrix, the input-side counterpart of the LED matrix row-scan driver. It drives one row low at a time, samples the column returns, and assembles a 16-bit raw frame. Each frame is debounced across consecutive identical frames. Outputs are a debounced key map plus a one-cycle press event carrying a 4-bit key code, consumed by the game/control logic that also feeds the LED matrix.

Parameters:
DWELL, 4, clk1K cycles each row is held active; must be at least 3 to cover the 2-flop synchroniser.
DEBOUNCE, 3, consecutive identical raw frames required before the debounced map updates; valid range 2..15.

Ports:
clk1K  input  1  scan clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
colI  input  4  column returns; active low with external pull-ups; asynchronous to clk1K.
rowO  output  4  row drive; one-hot active low, so row r low means rowO[r]=0.
keys  output  16  debounced key map; bit r*4+c set means key (row r, col c) is held.
keyCode  output  4  index r*4+c of the most recently reported press.
keyValid  output  1  one-cycle pulse when keyCode is updated.
keyDown  output  1  reduction OR of keys.

Behaviour:
- Reset (async, active-high) values: rowIdx=0 so rowO=4'b1110; dwellCnt=0; sync flops=4'b1111; raw=0; prevFrame=0; stableCnt=0; keys=0; keyCode=0; keyValid=0; keyDown=0.
- A reset mid-frame discards the partial frame. Scanning restarts at row 0, dwell 0 on the first clock after rst falls.
- Synchroniser: colI passes through 2 flops to give colS. The pressed bit is ~colS.
- Row scan: dwellCnt counts 0..DWELL-1.
  - On dwellCnt==DWELL-1, raw[rowIdx*4+c] is set to ~colS[c] for c=0..3.
  - On that same edge, rowIdx increments and wraps 3 to 0, and dwellCnt returns to 0.
- rowO is a registered decode of rowIdx. It changes only on the row-advance edge and never has 0 or 2+ rows low.
- Frame end is the sample edge with rowIdx==3. The completed frame F is raw with the row-3 bits just sampled.
- Debounce, at frame end:
  - If F==prevFrame, stableCnt increments, saturating at DEBOUNCE. Otherwise stableCnt=1.
  - prevFrame is set to F.
  - If the new stableCnt equals DEBOUNCE and F!=keys, then keys is set to F on the same edge.
- Press events, computed on a keys update:
  - newPress = F & ~keys(old).
  - If newPress!=0, keyCode is set to the index of the lowest set bit of newPress, and keyValid=1 for exactly one cycle.
  - Other simultaneous new presses are not reported.
  - Releases and changes to already-held keys produce no event.
- keyValid is 0 in all other cycles. keyCode holds its value between events.
- keyDown is registered and equals |keys. It updates on the same edge as keys.
- Latency: 4*DWELL cycles per frame. Once inputs are stable, keys updates DEBOUNCE to DEBOUNCE+1 frames after the change, i.e. 48 to 64 cycles at the defaults.
- Glitch handling: any frame that differs from the previous frame resets stableCnt to 1, so a single bouncing frame never reaches keys.
- Ghosting (3+ keys forming a rectangle) is not resolved. The raw frame is reported as-is.

Decomposition:
- Shared package: KEY_ROWS=4, KEY_COLS=4, KEY_NUM=16, and the one-hot active-low row decode function used by this block and the LED matrix driver.
- One sub-module, pri_enc16: 16-bit input, 4-bit lowest-set-bit index, plus a nonzero flag. Purely combinational; it is used to compute keyCode.

Test Plan:
- Reset: rst high for 3 cycles -> rowO=1110, keys=0, keyValid=0. After release, rowO steps 1110, 1101, 1011, 0111 every 4 cycles and wraps.
- Single press: hold key (2,1) (the model pulls colI[1] low while rowO[2]=0) -> within 64 cycles keys=16'h0200, keyCode=9, keyValid high for exactly 1 cycle, keyDown=1. Release -> keys=0 within 64 cycles, no keyValid.
- Bounce: toggle key 5 every 10 cycles for 200 cycles, then hold -> no keyValid during toggling. After the hold, one keyValid with keyCode=5.
- Simultaneous press: keys 3 and 12 asserted in the same cycle -> keys=16'h1008, one keyValid with keyCode=3. Then add key 0 -> keyValid with keyCode=0, keys=16'h1009.
- Mid-scan reset: assert rst while rowIdx=2 with key 7 held -> all outputs return to reset values immediately. After release, key 7 is reported again after the full debounce interval.
- Held key: hold key 15 for 1000 cycles -> exactly one keyValid pulse, keyCode=15, keys[15] stays 1 throughout.
